hiscore_xfer: RTL and testbench

HISCORE_XFER -- requirements
Module: hiscore_xfer

---
 rtl/hiscore_xfer_if.sv | 33 +++
 rtl/hiscore_xfer.sv | 161 ++++++++++++++++
 tb/tb_hiscore_xfer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hiscore_xfer_if.sv
// hiscore_xfer_if: transfer setup, MiSTer ioctl download, core hiscore port and dump stream.
// master is the hiscore_xfer side; slave is the surrounding system.
interface hiscore_xfer_if;
  logic [15:0] base_addr;
  logic [8:0]  length;
  logic        start_dump;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic [7:0]  hs_data_out;
  logic        hs_write;
  logic        pause_req;
  logic [7:0]  dump_data;
  logic        dump_valid;
  logic        dump_ready;
  logic        busy;
  logic        done;
  logic        restore_err;
  modport master (
    input  base_addr, length, start_dump, ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr,
    input  hs_data_out, dump_ready,
    output hs_address, hs_data_in, hs_write, pause_req, dump_data, dump_valid, busy, done, restore_err
  );
  modport slave (
    output base_addr, length, start_dump, ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr,
    output hs_data_out, dump_ready,
    input  hs_address, hs_data_in, hs_write, pause_req, dump_data, dump_valid, busy, done, restore_err
  );
endinterface

// File: rtl/hiscore_xfer.sv
// hiscore_xfer: pauses the core and dumps hiscore RAM to a valid/ready stream or restores it from an ioctl download.
// Define HISCORE_XFER_CHECKSUM_EN to append/verify a trailing ~sum byte.
module hiscore_xfer #(
  parameter logic [7:0] HS_INDEX = 8'd4,
  parameter int PAUSE_SETTLE = 4
) (
  input logic clk_49m,
  input logic reset_n,
  hiscore_xfer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, SETTLE, RD_ADDR, RD_WAIT, PUSH,
`ifdef HISCORE_XFER_CHECKSUM_EN
    CKSUM,
`endif
    RESTORE, FINISH
  } state_t;
`ifdef HISCORE_XFER_CHECKSUM_EN
  localparam state_t DUMP_END = CKSUM;
  logic [7:0] sum;
  logic ck_seen;
`else
  localparam state_t DUMP_END = FINISH;
`endif
  state_t state;
  logic restore;
  logic [8:0] idx;
  logic [7:0] cnt;
  logic dl, dl_q;
  logic buf_v;
  logic [24:0] buf_a;
  logic [7:0] buf_d;
  logic wr_v, in_rng, is_ck;
  logic [24:0] wr_a;
  logic [7:0] wr_d;
  // a buffered write from SETTLE always goes out before any newer one
  always_comb begin
    dl = bus.ioctl_download && bus.ioctl_index == HS_INDEX;
    wr_v = buf_v || bus.ioctl_wr;
    wr_a = buf_v ? buf_a : bus.ioctl_addr;
    wr_d = buf_v ? buf_d : bus.ioctl_data;
    in_rng = wr_a < {16'd0, bus.length};
    is_ck = wr_a == {16'd0, bus.length};
  end
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk_49m or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      restore <= 1'b0;
      idx <= '0;
      cnt <= '0;
      dl_q <= 1'b1;
      buf_v <= 1'b0;
      buf_a <= '0;
      buf_d <= '0;
      bus.hs_address <= '0;
      bus.hs_data_in <= '0;
      bus.hs_write <= 1'b0;
      bus.pause_req <= 1'b0;
      bus.dump_data <= '0;
      bus.dump_valid <= 1'b0;
      bus.done <= 1'b0;
      bus.restore_err <= 1'b0;
`ifdef HISCORE_XFER_CHECKSUM_EN
      sum <= '0;
      ck_seen <= 1'b0;
`endif
    end else begin
      dl_q <= dl;
      bus.hs_write <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if ((dl && !dl_q) || bus.start_dump) begin
          restore <= dl && !dl_q;
          state <= SETTLE;
          bus.pause_req <= 1'b1;
          bus.restore_err <= 1'b0;
          idx <= '0;
          cnt <= '0;
          buf_v <= 1'b0;
`ifdef HISCORE_XFER_CHECKSUM_EN
          sum <= '0;
          ck_seen <= 1'b0;
`endif
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (restore && bus.ioctl_wr) begin
            if (buf_v) bus.restore_err <= 1'b1;
            else begin
              buf_v <= 1'b1;
              buf_a <= bus.ioctl_addr;
              buf_d <= bus.ioctl_data;
            end
          end
          if (cnt == 8'(PAUSE_SETTLE - 1))
            state <= restore ? RESTORE : bus.length == 9'd0 ? DUMP_END : RD_ADDR;
        end
        RD_ADDR: begin
          bus.hs_address <= bus.base_addr + 16'(idx);
          cnt <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'd1) begin
            bus.dump_data <= bus.hs_data_out;
            bus.dump_valid <= 1'b1;
            state <= PUSH;
`ifdef HISCORE_XFER_CHECKSUM_EN
            sum <= sum + bus.hs_data_out;
`endif
          end
        end
        PUSH: if (bus.dump_ready) begin
          bus.dump_valid <= 1'b0;
          idx <= idx + 9'd1;
          state <= (idx + 9'd1 < bus.length) ? RD_ADDR : DUMP_END;
        end
`ifdef HISCORE_XFER_CHECKSUM_EN
        CKSUM: begin
          if (!bus.dump_valid) begin
            bus.dump_data <= ~sum;
            bus.dump_valid <= 1'b1;
          end else if (bus.dump_ready) begin
            bus.dump_valid <= 1'b0;
            state <= FINISH;
          end
        end
`endif
        RESTORE: begin
          if (wr_v && in_rng) begin
            bus.hs_write <= 1'b1;
            bus.hs_address <= bus.base_addr + wr_a[15:0];
            bus.hs_data_in <= wr_d;
`ifdef HISCORE_XFER_CHECKSUM_EN
            sum <= sum + wr_d;
`endif
          end
`ifdef HISCORE_XFER_CHECKSUM_EN
          if (wr_v && is_ck) begin
            ck_seen <= 1'b1;
            if (wr_d != ~sum) bus.restore_err <= 1'b1;
          end
          if (!bus.ioctl_download && !ck_seen && !(wr_v && is_ck)) bus.restore_err <= 1'b1;
`endif
          buf_v <= buf_v && bus.ioctl_wr;
          buf_a <= bus.ioctl_addr;
          buf_d <= bus.ioctl_data;
          if (!bus.ioctl_download) state <= FINISH;
        end
        FINISH: begin
          bus.done <= 1'b1;
          bus.pause_req <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hiscore_xfer.sv
// tb_hiscore_xfer: directed dump/restore/backpressure/wrap/abort vectors for hiscore_xfer.
module tb_hiscore_xfer;
`ifdef HISCORE_XFER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  logic clk_49m = 1'b0;
  logic reset_n = 1'b0;
  hiscore_xfer_if bus();
  hiscore_xfer dut (.clk_49m(clk_49m), .reset_n(reset_n), .bus(bus));
  always #5 clk_49m = ~clk_49m;
  logic [7:0] ram [0:65535];
  always @(posedge clk_49m) bus.hs_data_out <= ram[bus.hs_address];
  logic [7:0] dump_log[$];
  logic [15:0] dump_addr[$];
  logic [23:0] wr_log[$];
  int done_cnt = 0;
  int valid_cyc = 0;
  always @(posedge clk_49m) begin
    if (bus.dump_valid && bus.dump_ready) begin
      dump_log.push_back(bus.dump_data);
      dump_addr.push_back(bus.hs_address);
    end
    if (bus.hs_write) wr_log.push_back({bus.hs_address, bus.hs_data_in});
    if (bus.done) done_cnt++;
    if (bus.dump_valid) valid_cyc++;
  end
  int errors = 0;
  int checks = 0;
  int n0, w0, v0, d0, stall, bad;
  logic [7:0] ck_exp;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk_49m);
  endtask
  task automatic wait_done(input string tag);
    int s = done_cnt;
    for (int i = 0; i < 2000 && done_cnt == s; i++) tick(1);
    chk(tag, done_cnt - s, 1);
  endtask
  task automatic run_dump(input logic [15:0] base, input logic [8:0] len);
    bus.base_addr = base;
    bus.length = len;
    bus.start_dump = 1'b1;
    tick(1);
    bus.start_dump = 1'b0;
  endtask
  task automatic ioc_wr(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.ioctl_wr = 1'b1;
    tick(1);
    bus.ioctl_wr = 1'b0;
    tick(1);
  endtask
  task automatic restore_run(input logic [7:0] ckb);
    bus.ioctl_index = 8'd4;
    bus.base_addr = 16'h0100;
    bus.length = 9'd3;
    bus.ioctl_download = 1'b1;
    tick(8);
    ioc_wr(25'd0, 8'h01);
    ioc_wr(25'd1, 8'h02);
    ioc_wr(25'd2, 8'h03);
    ioc_wr(25'd3, ckb);
    bus.ioctl_download = 1'b0;
  endtask
  initial begin
    bus.base_addr = '0;
    bus.length = '0;
    bus.start_dump = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = '0;
    bus.ioctl_addr = '0;
    bus.ioctl_data = '0;
    bus.ioctl_wr = 1'b0;
    bus.dump_ready = 1'b1;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h11;
    ram[16'h0101] = 8'h22;
    ram[16'h0102] = 8'h33;
    ram[16'hFFFF] = 8'hA5;
    ram[16'h0000] = 8'h5A;
    ck_exp = ~(8'h11 + 8'h22 + 8'h33);
    tick(3);
    chk("rst_ctl", {bus.busy, bus.pause_req, bus.dump_valid, bus.hs_write, bus.done, bus.restore_err}, 0);
    chk("rst_bus", {bus.hs_address, bus.hs_data_in, bus.dump_data}, 0);
    reset_n = 1'b1;
    tick(2);
    // basic dump
    n0 = dump_log.size(); w0 = wr_log.size(); d0 = done_cnt;
    run_dump(16'h0100, 9'd3);
    chk("dump_busy", bus.busy, 1);
    chk("dump_pause_hi", bus.pause_req, 1);
    wait_done("dump_done");
    tick(2);
    chk("dump_n", dump_log.size() - n0, 3 + CK);
    chk("dump_b0", dump_log[n0], 8'h11);
    chk("dump_b1", dump_log[n0 + 1], 8'h22);
    chk("dump_b2", dump_log[n0 + 2], 8'h33);
    if (CK == 1) chk("dump_ck", dump_log[n0 + 3], ck_exp);
    chk("dump_pause_lo", bus.pause_req, 0);
    chk("dump_busy_lo", bus.busy, 0);
    chk("dump_one_done", done_cnt - d0, 1);
    chk("dump_no_wr", wr_log.size() - w0, 0);
    // backpressure on byte 1
    n0 = dump_log.size(); d0 = done_cnt; stall = 0; bad = 0;
    run_dump(16'h0100, 9'd3);
    for (int i = 0; i < 300 && done_cnt == d0; i++) begin
      if (dump_log.size() - n0 == 1 && (bus.dump_valid || stall > 0) && stall < 10) begin
        bus.dump_ready = 1'b0;
        stall++;
        if (!bus.dump_valid || bus.dump_data !== 8'h22) bad++;
      end else bus.dump_ready = 1'b1;
      tick(1);
    end
    bus.dump_ready = 1'b1;
    chk("bp_stall", stall, 10);
    chk("bp_stable", bad, 0);
    chk("bp_n", dump_log.size() - n0, 3 + CK);
    chk("bp_b1", dump_log[n0 + 1], 8'h22);
    chk("bp_b2", dump_log[n0 + 2], 8'h33);
    // restore with correct checksum byte
    w0 = wr_log.size(); v0 = valid_cyc;
    restore_run(8'hF9);
    wait_done("rs_done");
    chk("rs_n", wr_log.size() - w0, 3);
    chk("rs_w0", wr_log[w0], 24'h010001);
    chk("rs_w1", wr_log[w0 + 1], 24'h010102);
    chk("rs_w2", wr_log[w0 + 2], 24'h010203);
    chk("rs_err", bus.restore_err, 0);
    chk("rs_no_valid", valid_cyc - v0, 0);
    if (CK == 1) begin
      restore_run(8'h00);
      wait_done("rs_bad_done");
      chk("rs_bad_err", bus.restore_err, 1);
    end
    // two writes during SETTLE: first buffered, second dropped
    tick(2);
    w0 = wr_log.size();
    bus.base_addr = 16'h0200;
    bus.length = 9'd3;
    bus.ioctl_download = 1'b1;
    tick(1);
    bus.ioctl_addr = 25'd0; bus.ioctl_data = 8'h44; bus.ioctl_wr = 1'b1;
    tick(1);
    bus.ioctl_addr = 25'd1; bus.ioctl_data = 8'h55;
    tick(1);
    bus.ioctl_wr = 1'b0;
    tick(8);
    bus.ioctl_download = 1'b0;
    wait_done("ov_done");
    chk("ov_err", bus.restore_err, 1);
    chk("ov_n", wr_log.size() - w0, 1);
    chk("ov_w0", wr_log[w0], 24'h020044);
    // address wrap
    tick(2);
    n0 = dump_log.size();
    run_dump(16'hFFFF, 9'd2);
    chk("wrap_err_clr", bus.restore_err, 0);
    wait_done("wrap_done");
    chk("wrap_n", dump_log.size() - n0, 2 + CK);
    chk("wrap_b0", dump_log[n0], 8'hA5);
    chk("wrap_b1", dump_log[n0 + 1], 8'h5A);
    chk("wrap_a0", dump_addr[n0], 16'hFFFF);
    chk("wrap_a1", dump_addr[n0 + 1], 16'h0000);
    // simultaneous start: restore wins
    tick(2);
    w0 = wr_log.size(); v0 = valid_cyc;
    bus.base_addr = 16'h0100;
    bus.length = 9'd3;
    bus.start_dump = 1'b1;
    bus.ioctl_download = 1'b1;
    tick(1);
    bus.start_dump = 1'b0;
    tick(7);
    ioc_wr(25'd1, 8'h77);
    bus.ioctl_download = 1'b0;
    wait_done("sim_done");
    tick(3);
    chk("sim_no_valid", valid_cyc - v0, 0);
    chk("sim_n", wr_log.size() - w0, 1);
    chk("sim_w", wr_log[w0], 24'h010177);
    // zero length dump
    n0 = dump_log.size();
    run_dump(16'h0100, 9'd0);
    wait_done("len0_done");
    chk("len0_n", dump_log.size() - n0, CK);
    // reset abort while stalled in PUSH, with a download already high across reset
    tick(2);
    n0 = dump_log.size();
    bus.dump_ready = 1'b0;
    run_dump(16'h0100, 9'd3);
    for (int i = 0; i < 50 && !bus.dump_valid; i++) tick(1);
    chk("abort_pre_valid", bus.dump_valid, 1);
    bus.ioctl_download = 1'b1;
    tick(1);
    reset_n = 1'b0;
    #1;
    chk("abort_ctl", {bus.busy, bus.pause_req, bus.dump_valid, bus.hs_write, bus.done, bus.restore_err}, 0);
    chk("abort_bus", {bus.hs_address, bus.hs_data_in, bus.dump_data}, 0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    chk("no_restart", bus.busy, 0);
    bus.ioctl_download = 1'b0;
    bus.dump_ready = 1'b1;
    tick(2);
    run_dump(16'h0100, 9'd3);
    wait_done("post_done");
    chk("post_n", dump_log.size() - n0, 3 + CK);
    chk("post_b0", dump_log[n0], 8'h11);
    chk("post_b1", dump_log[n0 + 1], 8'h22);
    chk("post_b2", dump_log[n0 + 2], 8'h33);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
